// File: rtl/pipeline_scheduler.sv
// Issue controller between decoder and execute: owns the decode slot, tracks in-flight
// register writes, stalls on RAW hazards and sequences the flush after a taken branch.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_RUN   | normal issue; decode slot refilled whenever empty or issuing
// ST_FLUSH | younger work killed; all enables low until flush_cnt reaches 0
module pipeline_scheduler #(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_COUNT_L2 = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    fetch_valid,
    output logic                    fetch_enable,
    output logic                    decode_enable,
    input  logic [BIT_WIDTH-1:0]    decode_inst,
    output logic                    execute_enable,
    input  logic                    wb_valid,
    input  logic [REG_COUNT_L2-1:0] wb_addr,
    input  logic                    branch_taken,
    output logic                    flush,
    output logic                    stall,
    output logic [15:0]             stall_cycles
);

    localparam int REG_COUNT = 1 << REG_COUNT_L2;
    localparam int FCW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REG_COUNT_L2-1:0] LINK_REG = REG_COUNT_L2'(14);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                          state, state_nxt;
    logic [FCW-1:0]                  flush_cnt, flush_cnt_nxt;
    logic                            slot_valid;
    logic                            issue;
    logic                            hazard;
    logic [REG_COUNT-1:0][1:0]       pend_cnt;
    logic [REG_COUNT-1:0]            inc_vec, dec_vec;

    logic [1:0]                      fmt;
    logic                            i_bit, l_bit, link_bit;
    logic [3:0]                      opcode;
    logic [REG_COUNT_L2-1:0]         rn, rd, rm, dst;
    logic                            rn_rd, rm_rd, rd_rd, dst_vld;
    logic                            unused_inst_bits;

    assign fmt      = decode_inst[27:26];
    assign i_bit    = decode_inst[25];
    assign link_bit = decode_inst[24];
    assign opcode   = decode_inst[24:21];
    assign l_bit    = decode_inst[20];
    assign rn       = decode_inst[16 +: REG_COUNT_L2];
    assign rd       = decode_inst[12 +: REG_COUNT_L2];
    assign rm       = decode_inst[0 +: REG_COUNT_L2];
    assign unused_inst_bits = ^{decode_inst[BIT_WIDTH-1:28], decode_inst[11:4]};

    // Operand usage of the instruction sitting in the decode slot.
    always_comb begin
        rn_rd   = 1'b0;
        rm_rd   = 1'b0;
        rd_rd   = 1'b0;
        dst_vld = 1'b0;
        dst     = rd;
        case (fmt)
            2'b00: begin
                rn_rd   = 1'b1;
                rm_rd   = !i_bit;
                dst_vld = (opcode[3:2] != 2'b10);
            end
            2'b01: begin
                rn_rd = 1'b1;
                rm_rd = i_bit;
                if (l_bit) begin
                    dst_vld = 1'b1;
                end else begin
                    rd_rd = 1'b1;
                end
            end
            2'b10: begin
                if (link_bit) begin
                    dst_vld = 1'b1;
                    dst     = LINK_REG;
                end
            end
            default: ;
        endcase
    end

    assign hazard = (rn_rd   && (pend_cnt[rn]  != 2'd0))
                 || (rm_rd   && (pend_cnt[rm]  != 2'd0))
                 || (rd_rd   && (pend_cnt[rd]  != 2'd0))
                 || (dst_vld && (pend_cnt[dst] == 2'd3));

    always_ff @(posedge clk) begin
        if (nreset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        flush         = 1'b0;
        issue         = 1'b0;
        decode_enable = 1'b0;
        stall         = 1'b0;
        if (!nreset) begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        flush         = 1'b1;
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
                    end else begin
                        issue         = slot_valid && !hazard;
                        decode_enable = !slot_valid || issue;
                        stall         = slot_valid && hazard;
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    if (flush_cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - FCW'(1);
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign fetch_enable   = decode_enable;
    assign execute_enable = issue;

    // Issue always coincides with decode_enable, so refilling covers the clear-on-issue case.
    always_ff @(posedge clk) begin
        if (nreset || flush) begin
            slot_valid <= 1'b0;
        end else if (decode_enable) begin
            slot_valid <= fetch_valid;
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue && dst_vld) begin
            inc_vec[dst] = 1'b1;
        end
        if (wb_valid) begin
            dec_vec[wb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (nreset) begin
                pend_cnt[i] <= 2'd0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                pend_cnt[i] <= pend_cnt[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i] && (pend_cnt[i] != 2'd0)) begin
                pend_cnt[i] <= pend_cnt[i] - 2'd1;
            end
        end
        if (!nreset && wb_valid && !inc_vec[wb_addr] && (pend_cnt[wb_addr] == 2'd0)) begin
            $error("pipeline_scheduler: retire of r%0d with no write in flight", wb_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            stall_cycles <= 16'd0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Scoreboard bench for pipeline_scheduler: a fetcher/decoder model feeds directed
// programs, expected issues are queued with their cycle and checked by a monitor.
module tb_pipeline_scheduler;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_inst = 32'h0;
    logic        fetch_enable, decode_enable, execute_enable;
    logic [31:0] dec_reg = 32'h0;
    logic [31:0] decode_inst;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_addr = 4'h0;
    logic        branch_taken = 1'b0;
    logic        flush, stall;
    logic [15:0] stall_cycles;

    pipeline_scheduler #(.BIT_WIDTH(32), .REG_COUNT_L2(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .nreset(nreset), .fetch_valid(fetch_valid),
        .fetch_enable(fetch_enable), .decode_enable(decode_enable),
        .decode_inst(decode_inst), .execute_enable(execute_enable),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .branch_taken(branch_taken),
        .flush(flush), .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Decoder model: latches the fetched word whenever decode is enabled.
    always @(posedge clk) if (decode_enable) dec_reg <= fetch_inst;
    assign decode_inst = dec_reg;

    typedef struct {
        logic [31:0] inst;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] prog[$];
    int          wb_k[$];
    int          wb_r[$];
    int          br_k[$];
    int          fl_lo = -1, fl_hi = -2;
    int          k = -1;
    int          n_vec = 0, n_err = 0;
    int          stall_seen = 0;
    int          s0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (k=%0d)", nm, act, req, k);
        end
    endtask

    function automatic logic [31:0] dp(input logic [3:0] op, input logic ib,
                                       input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [3:0] rm);
        return {4'hE, 2'b00, ib, op, 1'b0, rn, rd, 8'h00, rm};
    endfunction

    function automatic logic [31:0] mem(input logic ld, input logic [3:0] rn,
                                        input logic [3:0] rd);
        return {4'hE, 2'b01, 1'b0, 4'b1100, ld, rn, rd, 8'h00, 4'h0};
    endfunction

    function automatic logic [31:0] br(input logic link);
        return {4'hE, 2'b10, 1'b1, link, 24'h000010};
    endfunction

    function automatic exp_t ex(input logic [31:0] inst, input int at);
        exp_t e;
        e.inst = inst;
        e.at   = at;
        return e;
    endfunction

    always @(negedge clk) begin
        if (stall) stall_seen++;
        if (execute_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", decode_inst, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_inst", decode_inst, mon_e.inst);
                check("issue_cycle", 32'(k), 32'(mon_e.at));
            end
        end
    end

    // Runs one directed program for ncyc cycles; k is the cycle index within the program.
    task automatic run(input int ncyc);
        int idx = 0;
        bit fe;
        for (int c = 0; c < ncyc; c++) begin
            k = c;
            fetch_valid = (idx < prog.size());
            fetch_inst  = fetch_valid ? prog[idx] : 32'h0;
            wb_valid    = 1'b0;
            wb_addr     = 4'h0;
            foreach (wb_k[j]) if (wb_k[j] == c) begin
                wb_valid = 1'b1;
                wb_addr  = 4'(wb_r[j]);
            end
            branch_taken = 1'b0;
            foreach (br_k[j]) if (br_k[j] == c) branch_taken = 1'b1;
            @(negedge clk);
            check("flush", {31'b0, flush}, {31'b0, (c >= fl_lo) && (c <= fl_hi)});
            fe = fetch_enable && fetch_valid;
            @(posedge clk);
            #1;
            if (fe) idx++;
        end
        fetch_valid = 1'b0;
        wb_valid = 1'b0;
        branch_taken = 1'b0;
        k = -1;
        check("missing_issues", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        prog.delete();
        wb_k.delete();
        wb_r.delete();
        br_k.delete();
        fl_lo = -1;
        fl_hi = -2;
    endtask

    initial begin
        // Reset held two cycles with a valid fetch presented.
        nreset = 1'b1;
        fetch_valid = 1'b1;
        fetch_inst = dp(4'd4, 1'b0, 4'd2, 4'd1, 4'd3);
        repeat (2) begin
            @(negedge clk);
            check("rst_fetch_en", {31'b0, fetch_enable}, 32'h0);
            check("rst_decode_en", {31'b0, decode_enable}, 32'h0);
            check("rst_exec_en", {31'b0, execute_enable}, 32'h0);
            check("rst_flush", {31'b0, flush}, 32'h0);
            check("rst_stall", {31'b0, stall}, 32'h0);
            @(posedge clk);
        end
        #1;
        nreset = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("rst_stall_cycles", {16'h0, stall_cycles}, 32'h0);
        check("post_rst_decode_en", {31'b0, decode_enable}, 32'h1);
        for (int i = 0; i < 16; i++) check("rst_scoreboard", 32'(dut.pend_cnt[i]), 32'h0);
        @(posedge clk);
        #1;

        // Back-to-back independent ADDs.
        prog = '{dp(4'd4, 1'b0, 4'd2, 4'd1, 4'd3), dp(4'd4, 1'b0, 4'd5, 4'd4, 4'd6)};
        exp_q.push_back(ex(prog[0], 1));
        exp_q.push_back(ex(prog[1], 2));
        wb_k = '{3, 4};
        wb_r = '{1, 4};
        s0 = stall_seen;
        run(6);
        check("t2_stalls", 32'(stall_seen - s0), 32'h0);

        // RAW on R1: SUB stalls three cycles, issues the cycle after the retire.
        prog = '{dp(4'd4, 1'b0, 4'd2, 4'd1, 4'd3), dp(4'd2, 1'b1, 4'd1, 4'd4, 4'd1)};
        exp_q.push_back(ex(prog[0], 1));
        exp_q.push_back(ex(prog[1], 5));
        wb_k = '{4, 6};
        wb_r = '{1, 4};
        s0 = stall_seen;
        run(8);
        check("t3_stalls", 32'(stall_seen - s0), 32'h3);
        check("t3_stall_cycles", {16'h0, stall_cycles}, 32'h3);

        // LDR R1 then STR R1 (stalls on Rd), CMP writes nothing, BL writes R14.
        prog = '{mem(1'b1, 4'd2, 4'd1), mem(1'b0, 4'd2, 4'd1),
                 dp(4'd10, 1'b0, 4'd1, 4'd0, 4'd2), br(1'b1)};
        exp_q.push_back(ex(prog[0], 1));
        exp_q.push_back(ex(prog[1], 4));
        exp_q.push_back(ex(prog[2], 5));
        exp_q.push_back(ex(prog[3], 6));
        wb_k = '{3};
        wb_r = '{1};
        s0 = stall_seen;
        run(7);
        check("t4_stalls", 32'(stall_seen - s0), 32'h2);
        check("t4_stall_cycles", {16'h0, stall_cycles}, 32'h5);
        check("t4_sb_r14", 32'(dut.pend_cnt[14]), 32'h1);
        check("t4_sb_r1", 32'(dut.pend_cnt[1]), 32'h0);
        check("t4_sb_r0", 32'(dut.pend_cnt[0]), 32'h0);
        wb_k = '{0};
        wb_r = '{14};
        run(2);
        check("t4_sb_r14_retired", 32'(dut.pend_cnt[14]), 32'h0);

        // Issue+retire of R7 in one cycle, then saturation stall on the fourth writer.
        prog = '{dp(4'd4, 1'b0, 4'd2, 4'd7, 4'd3), dp(4'd4, 1'b0, 4'd5, 4'd7, 4'd6),
                 dp(4'd4, 1'b0, 4'd8, 4'd7, 4'd9), dp(4'd4, 1'b0, 4'd10, 4'd7, 4'd11),
                 dp(4'd4, 1'b0, 4'd12, 4'd7, 4'd13)};
        exp_q.push_back(ex(prog[0], 1));
        exp_q.push_back(ex(prog[1], 2));
        exp_q.push_back(ex(prog[2], 3));
        exp_q.push_back(ex(prog[3], 4));
        exp_q.push_back(ex(prog[4], 7));
        wb_k = '{2, 6, 8, 9, 10};
        wb_r = '{7, 7, 7, 7, 7};
        s0 = stall_seen;
        run(12);
        check("t5_stalls", 32'(stall_seen - s0), 32'h2);
        check("t5_stall_cycles", {16'h0, stall_cycles}, 32'h7);
        check("t5_sb_r7", 32'(dut.pend_cnt[7]), 32'h0);

        // Taken branch at k=2 kills Y; second branch at k=3 ignored; fetch resumes at k=5.
        prog = '{dp(4'd4, 1'b0, 4'd2, 4'd1, 4'd3), dp(4'd4, 1'b0, 4'd5, 4'd4, 4'd6),
                 dp(4'd4, 1'b0, 4'd9, 4'd8, 4'd10), dp(4'd4, 1'b0, 4'd12, 4'd11, 4'd13)};
        exp_q.push_back(ex(prog[0], 1));
        exp_q.push_back(ex(prog[2], 6));
        exp_q.push_back(ex(prog[3], 7));
        br_k = '{2, 3};
        fl_lo = 2;
        fl_hi = 4;
        wb_k = '{3, 8, 9};
        wb_r = '{1, 8, 11};
        s0 = stall_seen;
        run(11);
        check("t6_stalls", 32'(stall_seen - s0), 32'h0);
        check("t6_sb_r4_killed", 32'(dut.pend_cnt[4]), 32'h0);

        // Reset in the middle of a stall clears slot, scoreboard and counter.
        prog = '{dp(4'd4, 1'b0, 4'd2, 4'd1, 4'd3), dp(4'd2, 1'b1, 4'd1, 4'd4, 4'd1)};
        exp_q.push_back(ex(prog[0], 1));
        s0 = stall_seen;
        run(4);
        check("t7_stalls", 32'(stall_seen - s0), 32'h2);
        check("t7_stall_cycles", {16'h0, stall_cycles}, 32'h9);
        nreset = 1'b1;
        @(negedge clk);
        check("t7_rst_stall", {31'b0, stall}, 32'h0);
        check("t7_rst_exec_en", {31'b0, execute_enable}, 32'h0);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        check("t7_stall_cycles_clr", {16'h0, stall_cycles}, 32'h0);
        check("t7_sb_r1_clr", 32'(dut.pend_cnt[1]), 32'h0);
        check("t7_slot_clr_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        prog = '{dp(4'd4, 1'b0, 4'd1, 4'd4, 4'd5)};
        exp_q.push_back(ex(prog[0], 1));
        wb_k = '{3};
        wb_r = '{4};
        s0 = stall_seen;
        run(5);
        check("t7_after_rst_stalls", 32'(stall_seen - s0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_scheduler.md
# pipeline_scheduler

Issue controller between decoder and execute stage of the 32-bit pipelined core. Owns the decode slot's valid bit and a per-register scoreboard of in-flight writes. Generates the fetcher/decoder/execute enables, stalls on read-after-write hazards, and sequences the pipeline flush after a taken branch. Also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- BIT_WIDTH, 32, instruction width
- REG_COUNT_L2, 4, register address width (16 registers)
- FLUSH_CYCLES, 2, cycles in FLUSH state after a taken branch (≥1)

- clk  in  1  clock
- nreset  in  1  reset, synchronous, active-high
- fetch_valid  in  1  fetcher has an instruction on fetcher_inst this cycle
- fetch_enable  out  1  fetcher may advance
- decode_enable  out  1  drives decoder enable; decoder latches fetcher_inst at next edge
- decode_inst  in  BIT_WIDTH  decoder_inst (instruction held in decode slot)
- execute_enable  out  1  issue decode_inst to execute this cycle
- wb_valid  in  1  an issued register write retires this cycle
- wb_addr  in  REG_COUNT_L2  register retired by wb_valid
- branch_taken  in  1  execute resolved a taken branch this cycle
- flush  out  1  kill younger work; fetcher redirects
- stall  out  1  decode slot valid but held by hazard
- stall_cycles  out  16  saturating count of stall cycles

## Operation
- Format from inst[27:26]: 00 data, 01 memory, 10 branch. Rn=[19:16], Rd=[15:12], Rm=[3:0].
- Sources: data reads Rn, plus Rm if inst[25]=0. Memory reads Rn, plus Rm if inst[25]=1. STR (inst[20]=0) also reads Rd. Branch reads none.
- Destination:
  - Data ops write Rd, except opcode [24:21] in 8–11 (TST/TEQ/CMP/CMN).
  - LDR writes Rd.
  - BL (inst[24]=1) writes R14.
  - STR and B write nothing.
- Condition field is ignored; execute asserts wb_valid once for every issued writer, even if its condition fails.
- Scoreboard: 16 × 2-bit pending counters.
  - Increment counter[dest] on issue.
  - Decrement counter[wb_addr] on wb_valid.
  - Both on the same register in the same cycle: counter unchanged.
  - Decrement at 0: counter stays 0 and a simulation $error fires.
- hazard = any source counter ≠ 0, or a destination counter == 3 (saturation guard).
- slot_valid register:
  - Set at edge when decode_enable=1 and fetch_valid=1.
  - Cleared when issued, when decode_enable is taken with fetch_valid=0, or on flush.
- RUN state, combinational:
  - issue = slot_valid & !hazard & !flush
  - execute_enable = issue
  - decode_enable = fetch_enable = !flush & (!slot_valid | issue)
  - stall = slot_valid & hazard & !flush
- FSM states: RUN, FLUSH.
  - RUN → FLUSH when branch_taken=1. In that cycle flush=1, all enables are 0, and slot_valid clears at the edge.
  - FLUSH: flush=1 and all enables 0. A down-counter loaded with FLUSH_CYCLES−1 runs; return to RUN when it reaches 0.
  - branch_taken is ignored while in FLUSH.
- Scoreboard is not cleared by flush: older instructions still retire, and killed instructions never incremented it.
- stall_cycles increments each cycle stall=1 and saturates at 16'hFFFF.

## Timing
- While nreset=1, at the next edge: state=RUN, slot_valid=0, all counters 0, stall_cycles=0, flush counter 0.
- During the reset cycle, fetch_enable, decode_enable, execute_enable, flush and stall are forced to 0.
- Throughput: 1 issue/cycle with no hazards. Fetch-to-issue latency is 1 cycle (decode_enable at t, execute_enable at t+1).
- Scoreboard updates are visible the cycle after issue or retire. A dependent instruction issues the cycle after the producer's wb_valid.
- flush is asserted in the branch_taken cycle plus FLUSH_CYCLES cycles. The first new decode_enable comes in the cycle after flush deasserts.
- Reset mid-FLUSH or mid-stall returns to the reset state at the next edge.

## Test plan
- Reset: hold nreset=1 for 2 cycles with fetch_valid=1 -> all enables 0; stall_cycles=0; scoreboard empty.
- ADD R1,R2,R3 then ADD R4,R5,R6 back-to-back -> execute_enable high on consecutive cycles; stall never asserted.
- ADD R1,R2,R3 then SUB R4,R1,#1, with wb_valid/wb_addr=1 three cycles after the first issue -> stall=1 for 3 cycles; SUB issues the cycle after wb; stall_cycles=3.
- STR R1,[R2] after LDR R1 -> stalls on Rd. CMP R1,R2 -> never increments the scoreboard. BL -> counter[14] becomes 1.
- Issue ADD R7 in the same cycle as wb_valid for R7 (counter was 1) -> counter[7] stays 1. A fourth in-flight writer to R7 stalls on saturation.
- branch_taken at cycle t with FLUSH_CYCLES=2 -> flush high t..t+2; no issue; slot_valid=0; decode_enable resumes at t+3; a second branch_taken at t+1 is ignored.
